// File: rtl/word_deserializer.sv
// Serial-to-parallel word assembler: frames on a marked bit, collects WIDTH bits
// into a shift register and hands each finished word to a separate output register.
module word_deserializer #(
    parameter int WIDTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame,
    input  logic             out_ready,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             overrun_q;
    logic             sync_err_q;

    logic [WIDTH-1:0] base_d;
    logic [WIDTH-1:0] shift_d;
    logic             accept_bit;
    logic             word_done;
    logic             load_word;
    logic             drop_word;
    logic             resync;

    // A framed bit always restarts from an empty register, so one shift path
    // covers both the first bit and every following bit.
    always_comb begin
        base_d = frame ? '0 : shreg_q;
        if (MSB_FIRST != 0) begin
            shift_d = {base_d[WIDTH-2:0], sin};
        end else begin
            shift_d = {sin, base_d[WIDTH-1:1]};
        end
    end

    assign accept_bit = sin_valid && (frame || (state_q == SHIFT));
    assign resync     = sin_valid && frame && (state_q == SHIFT);
    assign word_done  = sin_valid && !frame && (state_q == SHIFT) && (count_q == CNT_LAST);
    assign load_word  = word_done && (!out_valid_q || out_ready);
    assign drop_word  = word_done && !load_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shreg_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            if (word_done) begin
                state_q <= IDLE;
                count_q <= '0;
                shreg_q <= '0;
            end else if (accept_bit) begin
                state_q <= SHIFT;
                count_q <= frame ? CNT_ONE : (count_q + CNT_ONE);
                shreg_q <= shift_d;
            end

            // A word loading on the same edge as a consume keeps out_valid high.
            if (load_word) begin
                out_q       <= shift_d;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (drop_word) begin
                overrun_q <= 1'b1;
            end else if (clr) begin
                overrun_q <= 1'b0;
            end

            if (resync) begin
                sync_err_q <= 1'b1;
            end else if (clr) begin
                sync_err_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;
    assign sync_err  = sync_err_q;

endmodule
